// File: rtl/crc8_frame_ctrl.sv
// crc8_frame_ctrl: frames an upstream byte stream, appending one CRC8 byte from an external engine
module crc8_frame_ctrl #(
  parameter int MAX_LEN = 256
) (
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic [7:0]  s_data,
  input  logic        s_vld,
  input  logic        s_sop,
  input  logic        s_eop,
  output logic        s_rdy,
  output logic [7:0]  m_data,
  output logic        m_vld,
  output logic        m_sop,
  output logic        m_eop,
  input  logic        m_rdy,
  output logic [7:0]  crc_din,
  output logic        crc_sop,
  output logic        crc_din_vld,
  output logic        crc_cap,
  input  logic [7:0]  crc_dout,
  output logic        busy,
  output logic        frm_done,
  output logic        len_err,
  output logic        drop,
  output logic [15:0] frm_len
);
  typedef enum logic [1:0] {IDLE, INIT, DATA, CRC} state_t;
  state_t state, state_nx;
  logic [15:0] cnt;
  logic last;
  assign busy = state != IDLE;
  assign last = s_eop | (cnt == 16'(MAX_LEN - 1));
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      state   <= IDLE;
      cnt     <= '0;
      frm_len <= '0;
    end else begin
      state <= state_nx;
      if (state == INIT) cnt <= '0;
      else if (state == DATA && s_vld && m_rdy) cnt <= cnt + 16'd1;
      if (state == CRC && m_rdy) frm_len <= cnt;
    end
  end
  // IDLE outputs depend on live inputs, so they are gated by reset to stay 0 while it is held
  always_comb begin
    state_nx    = state;
    s_rdy       = 1'b0;
    m_data      = '0;
    m_vld       = 1'b0;
    m_sop       = 1'b0;
    m_eop       = 1'b0;
    crc_din     = '0;
    crc_sop     = 1'b0;
    crc_din_vld = 1'b0;
    crc_cap     = 1'b0;
    frm_done    = 1'b0;
    len_err     = 1'b0;
    drop        = 1'b0;
    case (state)
      IDLE: begin
        s_rdy    = rst_sys & ~s_sop;
        drop     = rst_sys & s_vld & ~s_sop;
        state_nx = (s_vld && s_sop) ? INIT : IDLE;
      end
      INIT: begin
        crc_sop  = 1'b1;
        state_nx = DATA;
      end
      DATA: begin
        s_rdy       = m_rdy;
        m_data      = s_data;
        m_vld       = s_vld;
        m_sop       = cnt == 16'd0;
        crc_din     = s_data;
        crc_din_vld = s_vld & m_rdy;
        if (s_vld && m_rdy && last) begin
          crc_cap  = 1'b1;
          len_err  = ~s_eop;
          state_nx = CRC;
        end
      end
      CRC: begin
        m_vld    = 1'b1;
        m_data   = crc_dout;
        m_eop    = 1'b1;
        frm_done = m_rdy;
        state_nx = m_rdy ? IDLE : CRC;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_crc8_frame_ctrl.sv
// tb_crc8_frame_ctrl: directed frames against hand-computed CRC8 (poly 0x07) downstream sequences
module tb_crc8_frame_ctrl;
  logic clk_sys = 0, rst_sys;
  logic [7:0] s_data, m_data, crc_din, crc_dout, crc_reg;
  logic s_vld, s_sop, s_eop, s_rdy, m_vld, m_sop, m_eop, m_rdy;
  logic crc_sop, crc_din_vld, crc_cap, busy, frm_done, len_err, drop;
  logic [15:0] frm_len;
  int checks = 0, errors = 0;
  int n_drop, n_len, n_done, n_vld, n_sop, n_both;
  logic [9:0] q[$];

  always #5 clk_sys = ~clk_sys;

  crc8_frame_ctrl #(.MAX_LEN(4)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys),
    .s_data(s_data), .s_vld(s_vld), .s_sop(s_sop), .s_eop(s_eop), .s_rdy(s_rdy),
    .m_data(m_data), .m_vld(m_vld), .m_sop(m_sop), .m_eop(m_eop), .m_rdy(m_rdy),
    .crc_din(crc_din), .crc_sop(crc_sop), .crc_din_vld(crc_din_vld), .crc_cap(crc_cap),
    .crc_dout(crc_dout), .busy(busy), .frm_done(frm_done), .len_err(len_err),
    .drop(drop), .frm_len(frm_len)
  );

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  always @(posedge clk_sys or negedge rst_sys)
    if (!rst_sys) crc_reg <= '0;
    else if (crc_sop) crc_reg <= '0;
    else if (crc_din_vld) crc_reg <= crc8(crc_reg, crc_din);
  assign crc_dout = crc_reg;

  always @(negedge clk_sys) begin
    if (m_vld && m_rdy) q.push_back({m_sop, m_eop, m_data});
    n_drop += int'(drop);
    n_len  += int'(len_err);
    n_done += int'(frm_done);
    n_vld  += int'(crc_din_vld);
    n_sop  += int'(crc_sop);
    n_both += int'(crc_sop & crc_din_vld);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    q.delete();
    n_drop = 0; n_len = 0; n_done = 0; n_vld = 0; n_sop = 0;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic sop, input logic eop, input int stall);
    int k;
    logic took;
    s_vld = 1; s_data = d; s_sop = sop; s_eop = eop; m_rdy = (stall == 0); k = 0;
    do begin
      @(negedge clk_sys); took = s_rdy;
      @(posedge clk_sys); #1;
      k++;
      if (k >= stall) m_rdy = 1;
    end while (!took && k < 64);
    if (!took) chk("push_timeout", 0, 1);
    s_vld = 0; s_sop = 0; s_eop = 0;
  endtask

  task automatic take_crc(input logic [7:0] exp, input int stall);
    int k;
    logic took;
    m_rdy = (stall == 0);
    for (k = 0; k < stall; k++) begin
      @(negedge clk_sys);
      chk("crc_hold", {m_vld, m_eop, m_data}, {2'b11, exp});
      @(posedge clk_sys); #1;
    end
    m_rdy = 1; k = 0;
    do begin
      @(negedge clk_sys); took = m_vld & m_eop;
      @(posedge clk_sys); #1;
      k++;
    end while (!took && k < 16);
    if (!took) chk("crc_timeout", 0, 1);
  endtask

  initial begin
    rst_sys = 0; s_data = 8'h55; s_vld = 1; s_sop = 0; s_eop = 0; m_rdy = 1;
    n_both = 0;
    clr();
    repeat (2) @(negedge clk_sys);
    chk("rst_outs", {s_rdy, m_vld, m_sop, m_eop, busy, drop, crc_sop, crc_din_vld, crc_cap, frm_done, len_err},
        0);
    chk("rst_data", {m_data, crc_din, frm_len}, 0);
    @(posedge clk_sys); #1;
    rst_sys = 1; s_vld = 0;
    repeat (2) @(posedge clk_sys); #1;
    clr();

    push_byte(8'h01, 1, 1, 0);
    take_crc(8'h07, 0);
    chk("t1_len", q.size(), 2);
    chk("t1_b0", q[0], 10'h201);
    chk("t1_b1", q[1], 10'h107);
    chk("t1_done", n_done, 1);
    chk("t1_crcsop", n_sop, 1);
    chk("t1_frmlen", frm_len, 1);
    chk("t1_busy", busy, 0);

    clr();
    push_byte(8'h01, 1, 0, 0);
    push_byte(8'h02, 0, 1, 0);
    take_crc(8'h1B, 0);
    chk("t2_len", q.size(), 3);
    chk("t2_seq", {q[0], q[1], q[2]}, {10'h201, 10'h002, 10'h11B});
    chk("t2_frmlen", frm_len, 2);

    clr();
    push_byte(8'h01, 1, 0, 3);
    push_byte(8'h02, 0, 1, 3);
    take_crc(8'h1B, 3);
    chk("t3_len", q.size(), 3);
    chk("t3_seq", {q[0], q[1], q[2]}, {10'h201, 10'h002, 10'h11B});
    chk("t3_vld", n_vld, 2);
    chk("t3_frmlen", frm_len, 2);

    clr();
    for (int i = 1; i <= 4; i++) push_byte(8'(i), i == 1, i == 4, 0);
    take_crc(8'hE3, 0);
    chk("t4_seq", {q[0], q[1], q[2], q[3], q[4]}, {10'h201, 10'h002, 10'h003, 10'h004, 10'h1E3});
    chk("t4_lenerr", n_len, 0);
    chk("t4_frmlen", frm_len, 4);

    clr();
    for (int i = 1; i <= 6; i++) push_byte(8'(i), i == 1, i == 6, 0);
    repeat (2) @(posedge clk_sys); #1;
    chk("t5_len", q.size(), 5);
    chk("t5_seq", {q[0], q[1], q[2], q[3], q[4]}, {10'h201, 10'h002, 10'h003, 10'h004, 10'h1E3});
    chk("t5_lenerr", n_len, 1);
    chk("t5_drop", n_drop, 2);
    chk("t5_frmlen", frm_len, 4);

    clr();
    s_vld = 1; s_sop = 0; s_data = 8'hAA;
    @(negedge clk_sys);
    chk("t6_rdy", {s_rdy, drop}, 2'b11);
    @(posedge clk_sys); #1;
    s_vld = 0;
    push_byte(8'hBB, 0, 0, 0);
    push_byte(8'hCC, 0, 1, 0);
    chk("t6_drop", n_drop, 3);
    chk("t6_out", q.size(), 0);
    chk("t6_crc", n_vld + n_sop, 0);

    clr();
    push_byte(8'h11, 1, 0, 0);
    s_vld = 1; s_data = 8'h22; rst_sys = 0;
    @(negedge clk_sys);
    chk("t7_rst", {s_rdy, m_vld, m_eop, busy, crc_din_vld, crc_cap, frm_done}, 0);
    @(posedge clk_sys); #1;
    rst_sys = 1; s_vld = 0;
    push_byte(8'h22, 0, 0, 0);
    push_byte(8'h33, 0, 1, 0);
    chk("t7_drop", n_drop, 2);
    push_byte(8'h01, 1, 1, 0);
    take_crc(8'h07, 0);
    chk("t7_seq", {q.size(), q[0], q[1], q[2]}, {32'd3, 10'h211, 10'h201, 10'h107});
    chk("t7_done", n_done, 1);
    chk("t7_frmlen", frm_len, 1);

    chk("sop_vld_excl", n_both, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/crc8_frame_ctrl.md
CRC8_FRAME_CTRL -- requirements
Module: crc8_frame_ctrl

Interface
REQ-001 SHALL have parameter: MAX_LEN, default 256, maximum payload bytes per frame (1..65535).
REQ-002 SHALL have port: clk_sys  input  1  single system clock; all state on its rising edge.
REQ-003 SHALL have port: rst_sys  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: s_data input 8, s_vld input 1, s_sop input 1, s_eop input 1, s_rdy output 1; upstream payload stream.
REQ-005 SHALL have ports: m_data output 8, m_vld output 1, m_sop output 1, m_eop output 1, m_rdy input 1; downstream stream, payload followed by one CRC byte.
REQ-006 SHALL have ports to the CRC8 engine (x^8+x^2+x+1, init 0x00): crc_din output 8, crc_sop output 1, crc_din_vld output 1, crc_cap output 1, crc_dout input 8.
REQ-007 SHALL have status ports: busy output 1 (state not IDLE); frm_done output 1 (one-cycle pulse); len_err output 1 (one-cycle pulse); drop output 1 (one-cycle pulse); frm_len output 16 (payload length of last completed frame).

Function
REQ-008 SHALL implement FSM states IDLE, INIT, DATA, CRC.
REQ-009 SHALL define a transfer as vld & rdy high on the same rising edge.
REQ-010 In IDLE, SHALL drive s_rdy = ~s_sop; a byte with s_vld=1 and s_sop=0 is discarded with drop=1 that cycle.
REQ-011 In IDLE, s_vld=1 and s_sop=1 SHALL move to INIT next cycle without consuming the byte.
REQ-012 In INIT (exactly one cycle), SHALL drive crc_sop=1, s_rdy=0, m_vld=0, clear the length counter, then enter DATA.
REQ-013 In DATA, SHALL drive m_data=s_data, m_vld=s_vld, s_rdy=m_rdy, crc_din=s_data, crc_din_vld=s_vld&m_rdy (combinational pass-through, zero latency).
REQ-014 In DATA, m_sop SHALL be 1 on the first payload transfer only; m_eop SHALL be 0 for all payload bytes.
REQ-015 In DATA, s_sop SHALL be ignored (treated as data).
REQ-016 Every DATA transfer SHALL increment a 16-bit length counter.
REQ-017 A DATA transfer with s_eop=1 SHALL assert crc_cap=1 that cycle and enter CRC next cycle.
REQ-018 A DATA transfer with s_eop=0 when counter = MAX_LEN-1 SHALL be treated as last: crc_cap=1, len_err=1, enter CRC. Residual upstream bytes are later dropped in IDLE.
REQ-019 In CRC, SHALL drive m_vld=1, m_data=crc_dout, m_eop=1, m_sop=0, s_rdy=0, crc_din_vld=0.
REQ-020 In CRC, m_data SHALL hold stable until m_rdy=1.
REQ-021 On the CRC-state transfer, SHALL pulse frm_done=1, load frm_len with the counter value, and return to IDLE next cycle.
REQ-022 SHALL drive crc_sop, crc_cap and crc_din_vld to 0 outside the states that assert them; crc_sop and crc_din_vld SHALL never both be 1.
REQ-023 m_rdy=0 in DATA SHALL stall both streams; no CRC update occurs.
REQ-024 A single-byte frame (sop and eop on the same byte) SHALL produce exactly two downstream bytes.

Reset
REQ-025 While rst_sys=0, SHALL hold state=IDLE, counter=0, frm_len=0, all outputs 0 including s_rdy.
REQ-026 Reset mid-frame SHALL abandon the frame immediately with no CRC byte and no frm_done; after release, bytes until the next s_sop are dropped.

Verification
REQ-027 Frame {0x01} (sop+eop), m_rdy=1 -> crc_sop pulse; downstream 0x01 (m_sop=1), then 0x07 (m_eop=1); frm_done=1, frm_len=1.
REQ-028 Frame {0x01,0x02} -> downstream 0x01, 0x02, 0x1B; frm_len=2.
REQ-029 Same frame with m_rdy low for 3 cycles on each byte -> identical output sequence; crc_din_vld pulses exactly twice; CRC byte held stable while m_rdy=0.
REQ-030 MAX_LEN=4, 6-byte frame, eop on byte 6 -> 4 payload bytes + CRC of those 4; len_err=1 on byte 4; bytes 5-6 dropped (2 drop pulses); frm_len=4.
REQ-031 Bytes without s_sop in IDLE -> s_rdy=1, drop=1 per byte, no downstream output, crc_* stay 0.
REQ-032 rst_sys asserted after byte 1 of a 3-byte frame -> outputs 0, no CRC byte; next sop frame {0x01} -> 0x01, 0x07.
